// File: rtl/hebb_pkg.sv
// rtl/hebb_pkg.sv - shared enums, width helpers and saturating add for the Hebbian weight engine
package hebb_pkg;

    typedef enum logic [1:0] {
        MODE_LEARN   = 2'b00,
        MODE_UNLEARN = 2'b01,
        MODE_CLEAR   = 2'b10,
        MODE_RECALL  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic int addr_width(input int n);
        return $clog2(n * n);
    endfunction

    // One extra bit above clog2(N) keeps the full +/- N*2^(W-1) range representable.
    function automatic int acc_width(input int n, input int w);
        return w + $clog2(n) + 1;
    endfunction

    // Symmetric clamp: the most negative code is never produced.
    function automatic int sat_add(input int w, input int delta, input int width);
        int hi;
        int sum;
        hi  = (1 << (width - 1)) - 1;
        sum = w + delta;
        if (sum > hi) begin
            return hi;
        end
        if (sum < -hi) begin
            return -hi;
        end
        return sum;
    endfunction

endpackage

// File: rtl/hebb_weight_engine_mac.sv
// rtl/hebb_weight_engine_mac.sv - combinational weight update and signed recall accumulate step
// Optional HEBB_SATURATE_EN selects clamped LEARN/UNLEARN instead of wrap-around.
module hebb_weight_engine_mac
    import hebb_pkg::*;
#(
    parameter int W_WIDTH = 8,
    parameter int ACC_W   = 13
) (
    input  mode_e                     mode,
    input  logic signed [W_WIDTH-1:0] w,
    input  logic                      p_pos,
    input  logic                      diag,
    input  logic                      s_pos,
    input  logic                      first,
    input  logic signed [ACC_W-1:0]   acc_in,
    output logic signed [W_WIDTH-1:0] w_next,
    output logic signed [ACC_W-1:0]   acc_out
);

    logic                    inc;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] base;

    always_comb begin
        inc    = ((mode == MODE_LEARN) == p_pos);
        w_next = w;
        if (!diag) begin
            case (mode)
                MODE_LEARN, MODE_UNLEARN: begin
`ifdef HEBB_SATURATE_EN
                    w_next = W_WIDTH'(sat_add(int'(w), inc ? 1 : -1, W_WIDTH));
`else
                    w_next = inc ? (w + W_WIDTH'(1)) : (w - W_WIDTH'(1));
`endif
                end
                MODE_CLEAR: w_next = '0;
                default:    w_next = w;
            endcase
        end
    end

    always_comb begin
        w_ext   = {{(ACC_W - W_WIDTH){w[W_WIDTH-1]}}, w};
        base    = first ? '0 : acc_in;
        acc_out = s_pos ? (base + w_ext) : (base - w_ext);
    end

endmodule

// File: rtl/hebb_weight_engine.sv
// rtl/hebb_weight_engine.sv - serial NxN Hebbian learn/unlearn/clear/recall engine, one weight per clock
// Optional HEBB_SATURATE_EN clamps LEARN/UNLEARN results to the symmetric signed range.
module hebb_weight_engine
    import hebb_pkg::*;
#(
    parameter int N_NEURONS = 16,
    parameter int W_WIDTH   = 8,
    localparam int AW       = addr_width(N_NEURONS)
) (
    input  logic                 CLOCK_50,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [N_NEURONS-1:0] pattern,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] state_out,
    input  logic [AW-1:0]        rd_addr,
    output logic [W_WIDTH-1:0]   rd_data
);

    localparam int NN    = N_NEURONS * N_NEURONS;
    localparam int IW    = $clog2(N_NEURONS);
    localparam int ACC_W = acc_width(N_NEURONS, W_WIDTH);
    localparam logic [AW-1:0] K_LAST = AW'(NN - 1);
    localparam logic [IW-1:0] J_LAST = IW'(N_NEURONS - 1);

    state_e                    state_q;
    state_e                    state_d;
    mode_e                     mode_q;
    logic [N_NEURONS-1:0]      pattern_q;
    logic [N_NEURONS-1:0]      new_q;
    logic [N_NEURONS-1:0]      new_vec;
    logic [AW-1:0]             k_q;
    logic [IW-1:0]             i_q;
    logic [IW-1:0]             j_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [W_WIDTH-1:0] wmem [NN];
    logic signed [W_WIDTH-1:0] w_cur;
    logic signed [W_WIDTH-1:0] w_next;
    logic                      accept;
    logic                      last_k;
    logic                      row_end;
    logic                      p_pos;
    logic                      new_bit;

    assign accept  = start && (state_q == IDLE);
    assign last_k  = (k_q == K_LAST);
    assign row_end = (j_q == J_LAST);
    assign w_cur   = wmem[k_q];
    assign p_pos   = (pattern_q[i_q] == pattern_q[j_q]);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

    hebb_weight_engine_mac #(
        .W_WIDTH (W_WIDTH),
        .ACC_W   (ACC_W)
    ) u_mac (
        .mode    (mode_q),
        .w       (w_cur),
        .p_pos   (p_pos),
        .diag    (i_q == j_q),
        .s_pos   (pattern_q[j_q]),
        .first   (j_q == '0),
        .acc_in  (acc_q),
        .w_next  (w_next),
        .acc_out (acc_next)
    );

    // A zero row sum is a tie: the neuron keeps its input bit.
    assign new_bit = (acc_next == '0) ? pattern_q[i_q] : ~acc_next[ACC_W-1];

    always_comb begin
        new_vec      = new_q;
        new_vec[i_q] = new_bit;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_k) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            mode_q    <= MODE_LEARN;
            pattern_q <= '0;
            k_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            acc_q     <= '0;
            new_q     <= '0;
            state_out <= '0;
        end else if (accept) begin
            mode_q    <= mode_e'(mode);
            pattern_q <= pattern;
            k_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
        end else if (state_q == RUN) begin
            k_q   <= k_q + AW'(1);
            acc_q <= acc_next;
            if (row_end) begin
                j_q        <= '0;
                i_q        <= i_q + IW'(1);
                new_q[i_q] <= new_bit;
            end else begin
                j_q <= j_q + IW'(1);
            end
            // Last row's bit is still combinational here, so publish new_vec rather than new_q.
            if (last_k && (mode_q == MODE_RECALL)) begin
                state_out <= new_vec;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            for (int n = 0; n < NN; n++) begin
                wmem[n] <= '0;
            end
        end else if (state_q == RUN) begin
            wmem[k_q] <= w_next;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (int'(rd_addr) < NN) begin
            rd_data <= wmem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_hebb_weight_engine.sv
// tb/tb_hebb_weight_engine.sv - scoreboard bench for hebb_weight_engine (N=16, W=8)
module tb_hebb_weight_engine;
    import hebb_pkg::*;

    localparam int N  = 16;
    localparam int W  = 8;
    localparam int NN = N * N;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n    = 1'b0;
    logic        start    = 1'b0;
    logic [1:0]  mode     = 2'b00;
    logic [15:0] pattern  = '0;
    logic        busy;
    logic        done;
    logic [15:0] state_out;
    logic [7:0]  rd_addr  = '0;
    logic [7:0]  rd_data;

    hebb_weight_engine #(
        .N_NEURONS (N),
        .W_WIDTH   (W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .pattern   (pattern),
        .busy      (busy),
        .done      (done),
        .state_out (state_out),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [15:0] state;
        int          cyc;
    } done_exp_t;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          busy_run = 0;
    done_exp_t   done_q[$];
    int          rd_q[$];
    int          rd_tag_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_valid = 1'b0;
    int          wm[NN];
    logic [15:0] exp_state = '0;

    done_exp_t   dm;
    int          re;
    int          rk;
    logic [7:0]  ev;

    always @(posedge CLOCK_50) begin
        cyc      <= cyc + 1;
        rd_valid <= rd_issue;
    end

    // Monitor: pops an expectation whenever the DUT presents a done pulse or read data.
    always @(negedge CLOCK_50) begin
        if (busy) busy_run = busy_run + 1;
        else      busy_run = 0;
        if (done) begin
            if (done_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done cyc=%0d state_out=%h", cyc, state_out);
            end else begin
                dm = done_q.pop_front();
                checks++;
                if (state_out !== dm.state) begin
                    failures++;
                    $display("FAIL state_out got=%h exp=%h", state_out, dm.state);
                end
                checks++;
                if (cyc != dm.cyc) begin
                    failures++;
                    $display("FAIL done_latency got_cyc=%0d exp_cyc=%0d", cyc, dm.cyc);
                end
                checks++;
                if (busy_run != 257) begin
                    failures++;
                    $display("FAIL busy_cycles got=%0d exp=257", busy_run);
                end
            end
        end
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rd_underflow rd_data=%h", rd_data);
            end else begin
                re = rd_q.pop_front();
                rk = rd_tag_q.pop_front();
                ev = 8'(re);
                checks++;
                if (rd_data !== ev) begin
                    failures++;
                    $display("FAIL weight k=%0d got=%0d exp=%0d", rk, $signed(rd_data), $signed(ev));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [15:0] pat, input logic [15:0] st, input bit push);
        done_exp_t d;
        @(negedge CLOCK_50);
        start   = 1'b1;
        mode    = m;
        pattern = pat;
        if (push) begin
            d.state = st;
            d.cyc   = cyc + 257;
            done_q.push_back(d);
        end
        @(negedge CLOCK_50);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((done_q.size() != 0 || busy) && n < 400) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL wait_idle timeout pending=%0d busy=%b", done_q.size(), busy);
        end
    endtask

    task automatic apply(input logic [1:0] m, input logic [15:0] pat);
        for (int k = 0; k < NN; k++) begin
            int i, j, p, v;
            i = k / N;
            j = k % N;
            if (i != j) begin
                p = (pat[i] == pat[j]) ? 1 : -1;
                case (m)
                    2'b00:   v = wm[k] + p;
                    2'b01:   v = wm[k] - p;
                    2'b10:   v = 0;
                    default: v = wm[k];
                endcase
`ifdef HEBB_SATURATE_EN
                if (v > 127)  v = 127;
                if (v < -127) v = -127;
`else
                if (v > 127)  v = v - 256;
                if (v < -128) v = v + 256;
`endif
                wm[k] = v;
            end
        end
    endtask

    task automatic run_cmd(input logic [1:0] m, input logic [15:0] pat);
        issue(m, pat, exp_state, 1'b1);
        apply(m, pat);
        wait_idle();
    endtask

    task automatic rd(input int k, input int e);
        @(negedge CLOCK_50);
        rd_addr  = 8'(k);
        rd_issue = 1'b1;
        rd_q.push_back(e);
        rd_tag_q.push_back(k);
    endtask

    task automatic rd_end();
        @(negedge CLOCK_50);
        rd_issue = 1'b0;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic read_all_model();
        for (int k = 0; k < NN; k++) rd(k, wm[k]);
        rd_end();
    endtask

    task automatic read_all_zero();
        for (int k = 0; k < NN; k++) rd(k, 0);
        rd_end();
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < NN; k++) wm[k] = 0;
        repeat (3) @(negedge CLOCK_50);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        checks++;
        if (state_out !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state_out got=%h exp=0000", state_out);
        end
        rst_n = 1'b1;
        read_all_zero();

        // LEARN one pattern and spot-check hand-computed weights plus the diagonal
        run_cmd(2'b00, 16'hFF00);
        rd(1 * 16 + 0, 1);
        rd(0 * 16 + 8, -1);
        rd(8 * 16 + 9, 1);
        for (int i = 0; i < N; i++) rd(i * 17, 0);
        rd_end();

        // Recall: a one-bit-corrupted pattern converges, the anti-pattern is stable
        exp_state = 16'hFF00;
        run_cmd(2'b11, 16'hFF01);
        exp_state = 16'h00FF;
        run_cmd(2'b11, 16'h00FF);
        read_all_model();

        run_cmd(2'b01, 16'hFF00);
        read_all_zero();

        // start pulses during RUN must be dropped
        issue(2'b00, 16'h1234, exp_state, 1'b1);
        apply(2'b00, 16'h1234);
        repeat (9) @(negedge CLOCK_50);
        start = 1'b1; mode = 2'b10;
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (89) @(negedge CLOCK_50);
        start = 1'b1; mode = 2'b01;
        @(negedge CLOCK_50);
        start = 1'b0;
        wait_idle();
        repeat (300) @(negedge CLOCK_50);
        read_all_model();

        run_cmd(2'b00, 16'hABCD);
        run_cmd(2'b10, 16'h0000);
        read_all_zero();

        // Reset in the middle of a LEARN aborts it and clears the matrix
        run_cmd(2'b00, 16'h0F0F);
        issue(2'b00, 16'h5555, exp_state, 1'b0);
        repeat (49) @(negedge CLOCK_50);
        rst_n = 1'b0;
        @(negedge CLOCK_50);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        rst_n = 1'b1;
        exp_state = 16'h0000;
        for (int k = 0; k < NN; k++) wm[k] = 0;
        repeat (300) @(negedge CLOCK_50);
        read_all_zero();

        // Overflow boundary: 130 LEARNs of the same pattern
        for (int r = 0; r < 130; r++) run_cmd(2'b00, 16'hAAAA);
`ifdef HEBB_SATURATE_EN
        rd(2, 127);
        rd(1, -127);
        rd(3, -127);
`else
        rd(2, -126);
        rd(1, 126);
        rd(3, 126);
`endif
        rd(0, 0);
        rd(17, 0);
        rd_end();

        checks++;
        if (done_q.size() != 0 || rd_q.size() != 0) begin
            failures++;
            $display("FAIL leftover done_q=%0d rd_q=%0d", done_q.size(), rd_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
